keypoint_fetch: RTL and testbench

- Downstream stage of the detect/filter keypoint stage.
- After detection finishes, reads both keypoint SRAMs (scale 0 = keypoint_1, scale 1 = keypoint_2). Each entry is 19 bits: {row[8:0], col[9:0]}.
- Emits keypoints as a valid/ready stream into the orientation/descriptor stage.
- Handles the 1-cycle SRAM read latency under backpressure with a 2-entry output FIFO.

---
 rtl/keypoint_fetch.sv | 210 +++++++++++++++++++++
 tb/tb_keypoint_fetch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypoint_fetch.sv
// keypoint_fetch: after detection, reads both keypoint SRAMs (scale 0, then scale 1)
// and streams {row, col, scale, index} downstream through a 2-entry skid FIFO that
// absorbs the one-cycle SRAM read latency under backpressure.
module keypoint_fetch #(
   parameter int KP_DEPTH = 2048,
   parameter int KP_AW    = 11,
   parameter int ROW_W    = 9,
   parameter int COL_W    = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [KP_AW:0]         kp1_count,
   input  logic [KP_AW:0]         kp2_count,
   output logic [KP_AW-1:0]       keypoint_1_rd_addr,
   input  logic [ROW_W+COL_W-1:0] keypoint_1_dout,
   output logic [KP_AW-1:0]       keypoint_2_rd_addr,
   input  logic [ROW_W+COL_W-1:0] keypoint_2_dout,
   output logic                   kp_valid,
   input  logic                   kp_ready,
   output logic [ROW_W-1:0]       kp_row,
   output logic [COL_W-1:0]       kp_col,
   output logic                   kp_scale,
   output logic [KP_AW:0]         kp_index,
   output logic                   busy,
   output logic                   done
);

   localparam int CW = KP_AW + 1;
   localparam int EW = ROW_W + COL_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(KP_DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD1   = 3'd1,
      S_RD2   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_c1;
   logic [CW-1:0]   r_c2;
   logic [KP_AW-1:0] r_addr1;
   logic [KP_AW-1:0] r_addr2;
   logic            r_inflight;
   logic            r_inflight_scale;
   logic [EW:0]     r_fifo [2];
   logic            r_wr_ptr;
   logic            r_rd_ptr;
   logic [1:0]      r_count;
   logic [CW-1:0]   r_index;
   logic            r_busy;
   logic            r_done;

   logic [CW-1:0]   w_c1;
   logic [CW-1:0]   w_c2;
   logic            w_pop;
   logic [2:0]      w_load;
   logic            w_issue;
   logic            w_last1;
   logic            w_last2;
   logic            w_drained;
   logic [EW:0]     w_push_data;
   logic [EW:0]     w_head;

   // Count clamping, issue decision, end-of-scale and drain detection.
   always_comb begin
      w_c1        = (kp1_count > DEPTH_C) ? DEPTH_C : kp1_count;
      w_c2        = (kp2_count > DEPTH_C) ? DEPTH_C : kp2_count;
      w_pop       = (r_count != 2'd0) && kp_ready;
      w_load      = {1'b0, r_count} + {2'b00, r_inflight};
      // The head leaving this cycle frees its slot, which keeps one read per cycle
      // flowing when downstream is always ready.
      if ((r_state == S_RD1) || (r_state == S_RD2)) begin
         w_issue = (w_load < 3'd2) || w_pop;
      end else begin
         w_issue = 1'b0;
      end
      w_last1     = ({1'b0, r_addr1} == (r_c1 - ONE_C));
      w_last2     = ({1'b0, r_addr2} == (r_c2 - ONE_C));
      // Finished once nothing is in flight and the FIFO is (or is becoming) empty.
      w_drained   = !r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));
      w_push_data = r_inflight_scale ? {1'b1, keypoint_2_dout} : {1'b0, keypoint_1_dout};
      w_head      = r_fifo[r_rd_ptr];
   end

   assign keypoint_1_rd_addr = r_addr1;
   assign keypoint_2_rd_addr = r_addr2;
   assign kp_valid           = (r_count != 2'd0);
   assign kp_scale           = w_head[EW];
   assign kp_row             = w_head[EW-1:COL_W];
   assign kp_col             = w_head[COL_W-1:0];
   assign kp_index           = r_index;
   assign busy               = r_busy;
   assign done               = r_done;

   // Pass sequencing: count latch, address walk per scale, drain and done pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_c1    <= '0;
         r_c2    <= '0;
         r_addr1 <= '0;
         r_addr2 <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_c1    <= w_c1;
                  r_c2    <= w_c2;
                  r_addr1 <= '0;
                  r_addr2 <= '0;
                  r_busy  <= 1'b1;
                  if (w_c1 != '0) begin
                     r_state <= S_RD1;
                  end else if (w_c2 != '0) begin
                     r_state <= S_RD2;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_RD1: begin
               if (w_issue) begin
                  // The last address is held so the port never wraps back to 0.
                  if (w_last1) begin
                     r_state <= (r_c2 != '0) ? S_RD2 : S_DRAIN;
                  end else begin
                     r_addr1 <= r_addr1 + KP_AW'(1);
                  end
               end
            end
            S_RD2: begin
               if (w_issue) begin
                  if (w_last2) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_addr2 <= r_addr2 + KP_AW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (w_drained) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // In-flight read marker and its scale tag, one cycle behind the address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inflight       <= 1'b0;
         r_inflight_scale <= 1'b0;
      end else begin
         r_inflight       <= w_issue;
         r_inflight_scale <= (r_state == S_RD2);
      end
   end

   // Two-entry output FIFO: push returning read data, pop on handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (r_inflight) begin
            r_fifo[r_wr_ptr] <= w_push_data;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({r_inflight, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Running keypoint index: cleared on an accepted start, advanced per handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_index <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_index <= '0;
      end else if (w_pop) begin
         r_index <= r_index + ONE_C;
      end
   end

endmodule

// File: tb/tb_keypoint_fetch.sv
// Self-checking bench for keypoint_fetch: SRAM models, a queue-based expected
// stream built directly from the counts and memory contents, and a monitor.
module tb_keypoint_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        kp_ready;
   logic [11:0] kp1_count;
   logic [11:0] kp2_count;
   logic [10:0] a1;
   logic [10:0] a2;
   logic [18:0] d1;
   logic [18:0] d2;
   logic        kp_valid;
   logic [8:0]  kp_row;
   logic [9:0]  kp_col;
   logic        kp_scale;
   logic [11:0] kp_index;
   logic        busy;
   logic        done;

   logic [18:0] mem1 [2048];
   logic [18:0] mem2 [2048];
   logic [19:0] exp_q [$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int hs_count, done_cnt, first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
   int exp_total, max_a1, last_idx, ready_mode, s_cyc;
   bit mon_en = 1'b0;
   bit prev_stall = 1'b0;
   bit wrap_seen;
   logic [63:0] prev_out;
   logic [10:0] prev_a1;

   always #5 clk = ~clk;

   keypoint_fetch dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .kp1_count          (kp1_count),
      .kp2_count          (kp2_count),
      .keypoint_1_rd_addr (a1),
      .keypoint_1_dout    (d1),
      .keypoint_2_rd_addr (a2),
      .keypoint_2_dout    (d2),
      .kp_valid           (kp_valid),
      .kp_ready           (kp_ready),
      .kp_row             (kp_row),
      .kp_col             (kp_col),
      .kp_scale           (kp_scale),
      .kp_index           (kp_index),
      .busy               (busy),
      .done               (done)
   );

   // Synchronous-read SRAM models: data one cycle after the address.
   always @(posedge clk) begin
      d1 <= mem1[a1];
      d2 <= mem2[a2];
   end

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Downstream ready: 0 = always, 1 = pattern 1,0,0, 2 = random.
   initial begin
      int phase = 0;
      kp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       kp_ready = 1'b1;
            1:       kp_ready = (phase % 3 == 0);
            default: kp_ready = 1'($urandom_range(0, 1));
         endcase
         phase++;
      end
   end

   // Monitor: scoreboard, output hold under stall, done/valid exclusion, address range.
   initial begin
      logic [19:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en) begin
            if (prev_stall)
               check_value("hold", {31'd0, kp_valid, kp_scale, kp_row, kp_col, kp_index}, prev_out);
            if (kp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
               check_value("done_with_valid", kp_valid, 0);
            end
            if (kp_valid && kp_ready) begin
               check_value("q_nonempty", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check_value("kp_data", {kp_scale, kp_row, kp_col}, e);
                  check_value("kp_index", kp_index, hs_count);
               end
               if (hs_count == 0) first_hs_cyc = cyc;
               last_hs_cyc = cyc;
               last_idx = kp_index;
               hs_count++;
            end
            prev_stall = kp_valid && !kp_ready;
            prev_out = {31'd0, kp_valid, kp_scale, kp_row, kp_col, kp_index};
            if (int'(a1) > max_a1) max_a1 = a1;
            if (prev_a1 == 11'd2047 && a1 == 11'd0 && busy) wrap_seen = 1'b1;
            prev_a1 = a1;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Fill memories and build the expected stream: scale 0 then scale 1, in address order.
   task automatic prepare(input int c1r, input int c2r, input int fill, input int mode);
      int c1, c2;
      c1 = (c1r > 2048) ? 2048 : c1r;
      c2 = (c2r > 2048) ? 2048 : c2r;
      for (int i = 0; i < 2048; i++) begin
         if (fill == 1) begin
            mem1[i] = {9'(i * 3 + 1), 10'(i)};
            mem2[i] = {9'(i + 7), 10'(1023 - i)};
         end else begin
            mem1[i] = 19'($urandom);
            mem2[i] = 19'($urandom);
         end
      end
      if (fill == 2) begin
         mem1[0] = {9'd5, 10'd10};
         mem1[1] = {9'd6, 10'd20};
         mem1[2] = {9'd7, 10'd30};
         mem2[0] = {9'd100, 10'd1};
         mem2[1] = {9'd101, 10'd2};
      end
      exp_q.delete();
      for (int i = 0; i < c1; i++) exp_q.push_back({1'b0, mem1[i]});
      for (int i = 0; i < c2; i++) exp_q.push_back({1'b1, mem2[i]});
      exp_total = c1 + c2;
      hs_count = 0;
      done_cnt = 0;
      first_valid_cyc = -1;
      first_hs_cyc = -1;
      last_hs_cyc = -1;
      done_cyc = -1;
      max_a1 = 0;
      last_idx = -1;
      wrap_seen = 1'b0;
      prev_a1 = a1;
      ready_mode = mode;
      mon_en = 1'b1;
   endtask

   task automatic kick(input int c1r, input int c2r);
      @(negedge clk);
      #1;
      kp1_count = 12'(c1r);
      kp2_count = 12'(c2r);
      start = 1'b1;
      s_cyc = cyc;
      @(negedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for done, then check totals and timing relative to start/handshakes.
   task automatic finish_pass(input int mode, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (done_cnt > 0) break;
         @(negedge clk);
         #1;
      end
      repeat (4) @(negedge clk);
      #1;
      check_value("done_pulses", done_cnt, 1);
      check_value("hs_total", hs_count, exp_total);
      check_value("q_empty", exp_q.size(), 0);
      check_value("busy_after", busy, 0);
      if (exp_total > 0) begin
         // Start sampled at edge E0: first kp_valid visible after E2.
         check_value("first_valid_lat", first_valid_cyc - s_cyc, 3);
         // Last handshake completes at edge Eh: done visible after Eh+1.
         check_value("done_after_hs", done_cyc - last_hs_cyc, 2);
      end else begin
         check_value("empty_done_lat", done_cyc - s_cyc, 2);
      end
      if (mode == 0 && exp_total > 0)
         check_value("back_to_back", last_hs_cyc - first_hs_cyc, exp_total - 1);
   endtask

   task automatic run_pass(input int c1r, input int c2r, input int mode, input int fill, input int budget);
      prepare(c1r, c2r, fill, mode);
      kick(c1r, c2r);
      finish_pass(mode, budget);
   endtask

   task automatic check_zero(input string tag);
      check_value({tag, "_valid"}, kp_valid, 0);
      check_value({tag, "_busy"}, busy, 0);
      check_value({tag, "_done"}, done, 0);
      check_value({tag, "_fields"}, {kp_scale, kp_row, kp_col, kp_index}, 0);
      check_value({tag, "_addr"}, {a1, a2}, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      kp1_count = 12'd0;
      kp2_count = 12'd0;
      ready_mode = 0;
      for (int i = 0; i < 2048; i++) begin
         mem1[i] = 19'd0;
         mem2[i] = 19'd0;
      end
      repeat (3) @(negedge clk);
      check_zero("reset");
      #1;
      rst_n = 1'b1;

      // Basic order, then the same data under 1,0,0 backpressure.
      run_pass(3, 2, 0, 2, 100);
      run_pass(3, 2, 1, 2, 100);

      // Empty scales.
      run_pass(0, 4, 0, 0, 100);
      run_pass(0, 0, 0, 0, 50);

      // Full depth with clamping of an oversized count.
      run_pass(3000, 2048, 0, 1, 5000);
      check_value("max_addr1", max_a1, 2047);
      check_value("addr1_wrap", wrap_seen, 0);
      check_value("last_index", last_idx, 4095);

      // Randomized passes.
      for (int it = 0; it < 8; it++)
         run_pass(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 2)), 0, 600);

      // Reset in the middle of a pass.
      prepare(20, 5, 0, 0);
      kick(20, 5);
      for (int k = 0; k < 100; k++) begin
         if (hs_count >= 10) break;
         @(negedge clk);
         #1;
      end
      check_value("reached_10", hs_count >= 10, 1);
      rst_n = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      check_zero("midreset");
      repeat (2) begin
         @(negedge clk);
         check_value("midreset_no_done", done, 0);
      end
      #1;
      rst_n = 1'b1;
      run_pass(6, 3, 2, 0, 200);

      // Start pulsed during RD2 must be ignored.
      prepare(4, 30, 0, 0);
      kick(4, 30);
      for (int k = 0; k < 200; k++) begin
         if (a2 >= 11'd5) break;
         @(negedge clk);
         #1;
      end
      check_value("in_rd2", (a2 >= 11'd5) && busy, 1);
      start = 1'b1;
      kp1_count = 12'd7;
      kp2_count = 12'd9;
      @(negedge clk);
      #1;
      start = 1'b0;
      finish_pass(0, 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
